// File: rtl/microcode_pkg.sv
// rtl/microcode_pkg.sv - shared types and field positions for the microcode loader
package microcode_pkg;

  localparam int MICROCODE_WORD_W = 32;
  localparam int BYTES_PER_WORD   = 4;

  // Boot byte address layout: [1:0] lane, upward from WORD_ADDR_LSB the word address.
  localparam int LANE_LSB      = 0;
  localparam int LANE_W        = 2;
  localparam int WORD_ADDR_LSB = LANE_LSB + LANE_W;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    READY_S = 2'd1,
    FAIL    = 2'd2
  } loader_state_t;

endpackage

// File: rtl/microcode_ram.sv
// rtl/microcode_ram.sv - microcode storage, one write port and one registered read port, no reset
module microcode_ram
  import microcode_pkg::*;
#(
  parameter int DEPTH_W = 10
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [DEPTH_W-1:0]          waddr_i,
  input  logic [MICROCODE_WORD_W-1:0] wdata_i,
  input  logic [DEPTH_W-1:0]          raddr_i,
  output logic [MICROCODE_WORD_W-1:0] rdata_o
);

  logic [MICROCODE_WORD_W-1:0] mem_q [2**DEPTH_W];
  logic [MICROCODE_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/microcode_loader.sv
// rtl/microcode_loader.sv - boot byte stream to microcode RAM loader with integrity checks
// Optional image checksum enabled by defining MICROCODE_LOADER_CHECKSUM_EN.
module microcode_loader
  import microcode_pkg::*;
#(
  parameter int DEPTH_W     = 10,
  parameter int BOOT_ADDR_W = 17
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [7:0]                  BOOT_DATA,
  input  logic [BOOT_ADDR_W-1:0]      BOOT_ADDR,
  input  logic                        N_BOOTED,
  input  logic                        CONTROL_N_WE,
  input  logic [DEPTH_W-1:0]          RD_ADDR,
  output logic [MICROCODE_WORD_W-1:0] RD_DATA,
  output logic                        READY,
  output logic                        ERR,
  output logic [DEPTH_W:0]            WORD_COUNT
);

  localparam logic [DEPTH_W:0] COUNT_MAX = {1'b1, {DEPTH_W{1'b0}}};

  loader_state_t             state_q, state_d;
  logic                      we_q;
  logic [LANE_W-1:0]         exp_lane_q, exp_lane_d;
  logic [2:0][7:0]           lanes_q, lanes_d;
  logic [DEPTH_W-1:0]        word_addr_q, word_addr_d;
  logic [DEPTH_W:0]          count_q, count_d;
  logic                      rd_valid_q;
  logic                      strobe, accept, end_ok, ram_we;
  logic [LANE_W-1:0]         lane;
  logic [DEPTH_W-1:0]        byte_waddr;
  logic                      in_range;
  logic [MICROCODE_WORD_W-1:0] ram_rdata;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
  logic [7:0]                sum_q, sum_d;
`endif

  assign strobe     = we_q && !CONTROL_N_WE;
  assign lane       = BOOT_ADDR[LANE_LSB +: LANE_W];
  assign byte_waddr = BOOT_ADDR[WORD_ADDR_LSB +: DEPTH_W];
  assign in_range   = (BOOT_ADDR >> (DEPTH_W + WORD_ADDR_LSB)) == '0;
  assign accept     = (lane == exp_lane_q) && in_range &&
                      ((exp_lane_q == '0) || (byte_waddr == word_addr_q));

  always_comb begin
    state_d     = state_q;
    exp_lane_d  = exp_lane_q;
    lanes_d     = lanes_q;
    word_addr_d = word_addr_q;
    count_d     = count_q;
    ram_we      = 1'b0;
    end_ok      = 1'b0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      LOAD: begin
        if (strobe) begin
          if (!accept) begin
            state_d = FAIL;
          end else begin
            exp_lane_d = exp_lane_q + 1'b1;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            sum_d = sum_q + BOOT_DATA;
`endif
            case (exp_lane_q)
              2'd0: begin
                lanes_d[0]  = BOOT_DATA;
                word_addr_d = byte_waddr;
              end
              2'd1: lanes_d[1] = BOOT_DATA;
              2'd2: lanes_d[2] = BOOT_DATA;
              default: begin
                ram_we = 1'b1;
                if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
              end
            endcase
          end
        end
        // End of boot judges the stream as it stands after this cycle's byte.
        end_ok = (exp_lane_d == '0);
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        end_ok = end_ok && (sum_d == 8'd0);
`endif
        if (!N_BOOTED && state_d == LOAD) begin
          state_d = end_ok ? READY_S : FAIL;
        end
      end
      READY_S: begin
        if (strobe) state_d = FAIL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= LOAD;
      we_q        <= 1'b1;
      exp_lane_q  <= '0;
      lanes_q     <= '0;
      word_addr_q <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= CONTROL_N_WE;
      exp_lane_q  <= exp_lane_d;
      lanes_q     <= lanes_d;
      word_addr_q <= word_addr_d;
      count_q     <= count_d;
      rd_valid_q  <= (state_d == READY_S);
`ifdef MICROCODE_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  microcode_ram #(.DEPTH_W(DEPTH_W)) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (word_addr_q),
    .wdata_i ({BOOT_DATA, lanes_q[2], lanes_q[1], lanes_q[0]}),
    .raddr_i (RD_ADDR),
    .rdata_o (ram_rdata)
  );

  assign RD_DATA    = rd_valid_q ? ram_rdata : '0;
  assign READY      = (state_q == READY_S);
  assign ERR        = (state_q == FAIL);
  assign WORD_COUNT = count_q;

endmodule

// File: doc/microcode_loader.md
# microcode_loader

Receiving end of the boot write stream. While `N_BOOTED` is high, the bootstrapper drives bytes on `BOOT_DATA`/`BOOT_ADDR` and pulses `CONTROL_N_WE` low. This block detects each write pulse, assembles four consecutive bytes into a 32-bit control word, commits it to an internal microcode RAM, and checks stream integrity. Once boot ends it raises `READY` and serves the control unit through a registered read port.

## Interface
Parameters:
- `DEPTH_W`, default 10: word-address bits stored; RAM holds 2^`DEPTH_W` 32-bit words.
- `BOOT_ADDR_W`, default 17: width of the boot byte address.

Ports:
- `CLK`  in  1: the only clock; all logic is on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `BOOT_DATA`  in  8: boot byte.
- `BOOT_ADDR`  in  `BOOT_ADDR_W`: boot byte address; [1:0] is the lane, [`DEPTH_W`+1:2] is the word address.
- `N_BOOTED`  in  1: high while booting, low once boot is complete.
- `CONTROL_N_WE`  in  1: active-low write strobe. It is synchronous to `CLK` and each low pulse lasts at least 1 cycle.
- `RD_ADDR`  in  `DEPTH_W`: read word address.
- `RD_DATA`  out  32: read data.
- `READY`  out  1: microcode loaded and valid.
- `ERR`  out  1: sticky stream error.
- `WORD_COUNT`  out  `DEPTH_W`+1: number of words committed.

## Operation
- Write strobe:
  - `we_q` registers `CONTROL_N_WE`.
  - Strobe = `we_q`==1 && `CONTROL_N_WE`==0 (falling edge). Exactly one strobe per pulse.
- States: `LOAD`, `READY_S`, `FAIL`. Reset enters `LOAD`.
- `LOAD`, on strobe:
  - Lane check: lane must equal `exp_lane` (2-bit counter, reset 0).
  - Range check: `BOOT_ADDR` bits above `DEPTH_W`+1 must be 0.
  - Word check: for lanes 1–3, the word address must equal the address latched at lane 0.
  - If any check fails: go to `FAIL` and set `ERR`.
  - Otherwise store the byte in the lane register and increment `exp_lane` (wraps 3→0).
  - On lane 3: write {lane3, lane2, lane1, lane0} (lane 0 = bits [7:0]) to RAM at the latched word address. Increment `WORD_COUNT`, saturating at 2^`DEPTH_W`.
- `LOAD`, when `N_BOOTED` is sampled low:
  - If `exp_lane`==0 and the checksum check passes (when compiled in): go to `READY_S`.
  - Otherwise: go to `FAIL` and set `ERR`.
  - A strobe in the same cycle is processed first; the end-of-boot check uses the post-strobe `exp_lane`.
- `READY_S`:
  - Any strobe → `FAIL`, `ERR`=1; RAM is not written.
  - `N_BOOTED` returning high is ignored.
- `FAIL`: terminal until `RST`. No RAM writes.
- Read port: `RD_DATA` = RAM[`RD_ADDR`] registered. It outputs 0 whenever the state (as of the same edge) is not `READY_S`.
- Overwriting the same word twice in `LOAD` is legal; the last write wins and `WORD_COUNT` counts both.

## Timing
- Reset values:
  - `RD_DATA`=0, `READY`=0, `ERR`=0, `WORD_COUNT`=0.
  - `exp_lane`=0, `we_q`=1, state=`LOAD`.
  - RAM contents are not cleared.
- Strobe detection: the byte is captured on the first rising edge at which `CONTROL_N_WE` is low.
- RAM commit happens on the same edge that captures lane 3.
- `READY` rises 1 cycle after the edge at which `N_BOOTED` is sampled low.
- Read latency is 1 cycle, with no stall and no handshake.
- `RST` mid-load discards partial lanes, count and state; the reload starts from lane 0.

## Configuration
- `MICROCODE_LOADER_CHECKSUM_EN`:
  - Defined: an 8-bit running sum (mod 256) of every accepted byte, reset 0. The `LOAD`→`READY_S` transition additionally requires sum==0; a nonzero sum gives `FAIL`. The image's final byte is chosen by the image builder to zero the sum.
  - Undefined: no sum register and no checksum condition.

## Structure
- Shared package `microcode_pkg`:
  - state enum `loader_state_t` (`LOAD`, `READY_S`, `FAIL`)
  - `MICROCODE_WORD_W`=32
  - `BYTES_PER_WORD`=4
  - lane field positions
- Sub-module `microcode_ram`:
  - single write port, registered read port
  - parameter `DEPTH_W`
  - storage only, no reset

## Test plan
- **Clean load:** write 8 bytes 0x11..0x88 to addresses 0..7, then drop `N_BOOTED`. Required: `READY`=1 one cycle later, `WORD_COUNT`=2, `ERR`=0; `RD_ADDR`=0 gives 0x44332211 after 1 cycle, `RD_ADDR`=1 gives 0x88776655.
- **Lane skip:** write lane 0 at address 0, then lane 2 at address 2. Required: `ERR`=1 and `FAIL` entered. After boot ends, `READY`=0 and `RD_DATA`=0.
- **Partial word at boot end:** write 3 bytes, then `N_BOOTED`=0. Required: `ERR`=1, `READY`=0, `WORD_COUNT`=0.
- **Long strobe, out of range, and post-boot writes:**
  - A single 5-cycle `CONTROL_N_WE` low pulse is captured once; `exp_lane` advances by 1 only.
  - A write to address 0x10000 with `DEPTH_W`=10 gives `ERR`=1.
  - A write strobe while `READY` gives `ERR`=1, `READY`=0, and RAM unchanged.
- **Reset mid-load:** 2 bytes written, then `RST` for 1 cycle, then a clean 4-byte load of 0xDEADBEEF. Required: `READY`=1, word 0 = 0xDEADBEEF, `WORD_COUNT`=1.
- **Checksum (with `MICROCODE_LOADER_CHECKSUM_EN`):**
  - Bytes 0x01, 0x02, 0x03, 0xFA give `READY`=1.
  - Last byte 0xFB instead gives `ERR`=1.
  - Without the macro, 0xFB gives `READY`=1.
